// File: rtl/pkt_con_pkg.sv
// Shared types and constants for the node/topology packet connection receive side.
package pkt_con_pkg;

  localparam int unsigned X_NUM      = 7;
  localparam int unsigned Y_NUM      = 7;
  localparam int unsigned TOTAL_NUM  = X_NUM + Y_NUM;
  localparam int unsigned PKT_TYPE_W = 4;
  localparam int unsigned PKT_ID_W   = 4;
  localparam int unsigned PKT_FLIT_W = 16;
  localparam int unsigned PORT_W     = 4;

  typedef logic [PORT_W-1:0] port_idx_t;

  typedef struct packed {
    logic                  qos;
    logic [PKT_TYPE_W-1:0] typ;
    logic [PKT_ID_W-1:0]   src;
    logic [PKT_ID_W-1:0]   tgt;
    logic [PKT_FLIT_W-1:0] data;
  } pkt_t;

  typedef struct packed {
    pkt_t      pkt;
    port_idx_t port;
  } fifo_ent_t;

  // Round-robin successor of a link index among n links.
  function automatic port_idx_t next_idx(input port_idx_t i, input int unsigned n);
    return ((32'(i) + 32'd1) >= n) ? '0 : i + port_idx_t'(1);
  endfunction

endpackage

// File: rtl/pkt_con_rr_arb.sv
// Round-robin arbiter: first requester at or after ptr, wrapping N-1 -> 0.
module pkt_con_rr_arb #(
  parameter int unsigned N     = 14,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);

  // Scan N positions starting at ptr; the first active request wins.
  always_comb begin
    int unsigned c;
    logic        found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      c = 32'(ptr) + k;
      if (c >= N) c = c - N;
      if (!found && req[IDX_W'(c)]) begin
        found              = 1'b1;
        gnt[IDX_W'(c)]     = 1'b1;
        idx                = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/pkt_con_rx_arb.sv
// Receive-side arbiter: merges X/Y links into one ejection port through a small FIFO.
module pkt_con_rx_arb #(
  parameter int unsigned X_NUM  = pkt_con_pkg::X_NUM,
  parameter int unsigned Y_NUM  = pkt_con_pkg::Y_NUM,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned TYPE_W = pkt_con_pkg::PKT_TYPE_W,
  parameter int unsigned ID_W   = pkt_con_pkg::PKT_ID_W,
  parameter int unsigned FLIT_W = pkt_con_pkg::PKT_FLIT_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [X_NUM-1:0]              x_vld,
  input  logic [X_NUM-1:0]              x_qos,
  input  logic [X_NUM*TYPE_W-1:0]       x_type,
  input  logic [X_NUM*ID_W-1:0]         x_src,
  input  logic [X_NUM*ID_W-1:0]         x_tgt,
  input  logic [X_NUM*FLIT_W-1:0]       x_data,
  output logic [X_NUM-1:0]              x_rdy,
  input  logic [Y_NUM-1:0]              y_vld,
  input  logic [Y_NUM-1:0]              y_qos,
  input  logic [Y_NUM*TYPE_W-1:0]       y_type,
  input  logic [Y_NUM*ID_W-1:0]         y_src,
  input  logic [Y_NUM*ID_W-1:0]         y_tgt,
  input  logic [Y_NUM*FLIT_W-1:0]       y_data,
  output logic [Y_NUM-1:0]              y_rdy,
  output logic                          out_vld,
  input  logic                          out_rdy,
  output logic                          out_qos,
  output logic [TYPE_W-1:0]             out_type,
  output logic [ID_W-1:0]               out_src,
  output logic [ID_W-1:0]               out_tgt,
  output logic [FLIT_W-1:0]             out_data,
  output logic [3:0]                    out_port,
  output logic [$clog2(DEPTH+1)-1:0]    fifo_cnt,
  output logic                          proto_err
);

  import pkt_con_pkg::*;

  localparam int unsigned N_LINK = X_NUM + Y_NUM;
  localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW     = $clog2(DEPTH + 1);

  logic [N_LINK-1:0] req;
  logic [N_LINK-1:0] qos_req;
  logic [N_LINK-1:0] gnt_hi;
  logic [N_LINK-1:0] gnt_all;
  logic [N_LINK-1:0] gnt;
  logic [N_LINK-1:0] err_hit;
  pkt_t              link_pkt [N_LINK];
  port_idx_t         idx_hi;
  port_idx_t         idx_all;
  port_idx_t         win_idx;
  logic              any_qos;
  logic              can_push;
  logic              push;
  logic              pop;

  port_idx_t         ptr_hi_q, ptr_hi_d;
  port_idx_t         ptr_all_q, ptr_all_d;
  fifo_ent_t         mem_q [DEPTH];
  fifo_ent_t         mem_d [DEPTH];
  logic [AW-1:0]     wr_q, wr_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N_LINK-1:0] pend_q, pend_d;
  pkt_t              prev_q [N_LINK];
  pkt_t              prev_d [N_LINK];
  logic              perr_q, perr_d;
  fifo_ent_t         head;

  assign req     = {y_vld, x_vld};
  assign qos_req = req & {y_qos, x_qos};

  // Unpack the flat link buses into one packet per link index.
  for (genvar i = 0; i < X_NUM; i++) begin : g_x
    assign link_pkt[i] = {x_qos[i], x_type[i*TYPE_W +: TYPE_W], x_src[i*ID_W +: ID_W],
                          x_tgt[i*ID_W +: ID_W], x_data[i*FLIT_W +: FLIT_W]};
  end
  for (genvar i = 0; i < Y_NUM; i++) begin : g_y
    assign link_pkt[X_NUM+i] = {y_qos[i], y_type[i*TYPE_W +: TYPE_W], y_src[i*ID_W +: ID_W],
                                y_tgt[i*ID_W +: ID_W], y_data[i*FLIT_W +: FLIT_W]};
  end

  pkt_con_rr_arb #(.N(N_LINK)) u_arb_hi (
    .req (qos_req),
    .ptr (ptr_hi_q),
    .gnt (gnt_hi),
    .idx (idx_hi)
  );

  pkt_con_rr_arb #(.N(N_LINK)) u_arb_all (
    .req (req),
    .ptr (ptr_all_q),
    .gnt (gnt_all),
    .idx (idx_all)
  );

  // Class select and full inhibit; a same-cycle pop never frees a slot.
  always_comb begin
    any_qos  = |qos_req;
    can_push = rst_n && (cnt_q != CW'(DEPTH));
    win_idx  = any_qos ? idx_hi : idx_all;
    gnt      = '0;
    if (can_push) gnt = any_qos ? gnt_hi : gnt_all;
    push     = |gnt;
  end

  assign x_rdy = gnt[X_NUM-1:0];
  assign y_rdy = gnt[N_LINK-1:X_NUM];

  // Only the winning class advances its pointer.
  always_comb begin
    ptr_hi_d  = ptr_hi_q;
    ptr_all_d = ptr_all_q;
    if (push) begin
      if (any_qos) ptr_hi_d  = next_idx(win_idx, N_LINK);
      else         ptr_all_d = next_idx(win_idx, N_LINK);
    end
  end

  // Ejection FIFO next state.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    pop   = (cnt_q != '0) && out_rdy;
    if (push) begin
      mem_d[wr_q] = '{pkt: link_pkt[win_idx], port: win_idx};
      wr_d        = (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + AW'(1);
    end
    if (pop) rd_d = (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + AW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Per-link hold check: a stalled request must stay valid with identical payload.
  for (genvar i = 0; i < N_LINK; i++) begin : g_chk
    assign err_hit[i] = pend_q[i] && (!req[i] || (link_pkt[i] != prev_q[i]));
  end

  // Protocol monitor next state.
  always_comb begin
    pend_d = req & ~gnt;
    prev_d = link_pkt;
    perr_d = perr_q | (|err_hit);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_hi_q  <= '0;
      ptr_all_q <= '0;
      mem_q     <= '{default: '0};
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      pend_q    <= '0;
      prev_q    <= '{default: '0};
      perr_q    <= 1'b0;
    end else begin
      ptr_hi_q  <= ptr_hi_d;
      ptr_all_q <= ptr_all_d;
      mem_q     <= mem_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      prev_q    <= prev_d;
      perr_q    <= perr_d;
    end
  end

  // Head of FIFO drives the ejection port; fields read zero while empty.
  always_comb begin
    head     = mem_q[rd_q];
    out_vld  = (cnt_q != '0);
    out_qos  = 1'b0;
    out_type = '0;
    out_src  = '0;
    out_tgt  = '0;
    out_data = '0;
    out_port = '0;
    if (out_vld) begin
      out_qos  = head.pkt.qos;
      out_type = head.pkt.typ;
      out_src  = head.pkt.src;
      out_tgt  = head.pkt.tgt;
      out_data = head.pkt.data;
      out_port = head.port;
    end
  end

  assign fifo_cnt  = cnt_q;
  assign proto_err = perr_q;

endmodule

// File: tb/tb_pkt_con_rx_arb.sv
// Self-checking bench for pkt_con_rx_arb: vector table, directed corner sequences, random vs model.
module tb_pkt_con_rx_arb;
  import pkt_con_pkg::*;

  localparam int unsigned XN    = 7;
  localparam int unsigned YN    = 7;
  localparam int unsigned NL    = XN + YN;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TW    = PKT_TYPE_W;
  localparam int unsigned IW    = PKT_ID_W;
  localparam int unsigned FW    = PKT_FLIT_W;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int unsigned PW    = 1 + TW + 2 * IW + FW;

  typedef struct packed {
    logic          q;
    logic [TW-1:0] t;
    logic [IW-1:0] s;
    logic [IW-1:0] g;
    logic [FW-1:0] d;
    logic [3:0]    p;
  } ent_t;

  typedef struct {
    logic [NL-1:0] vld;
    logic [NL-1:0] qos;
    logic [NL-1:0] exp_rdy;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [XN-1:0]    x_vld, x_qos, x_rdy;
  logic [XN*TW-1:0] x_type;
  logic [XN*IW-1:0] x_src, x_tgt;
  logic [XN*FW-1:0] x_data;
  logic [YN-1:0]    y_vld, y_qos, y_rdy;
  logic [YN*TW-1:0] y_type;
  logic [YN*IW-1:0] y_src, y_tgt;
  logic [YN*FW-1:0] y_data;
  logic             out_vld, out_rdy, out_qos;
  logic [TW-1:0]    out_type;
  logic [IW-1:0]    out_src, out_tgt;
  logic [FW-1:0]    out_data;
  logic [3:0]       out_port;
  logic [CW-1:0]    fifo_cnt;
  logic             proto_err;

  logic [NL-1:0] lv, lq, rdy;
  logic [TW-1:0] lt [NL];
  logic [IW-1:0] ls [NL];
  logic [IW-1:0] lg [NL];
  logic [FW-1:0] ld [NL];

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  ent_t          mq[$];
  int            phi, plo;
  logic          perr;
  logic [NL-1:0] ppend;
  logic [PW-1:0] pprev [NL];
  vec_t          tbl [10];

  always #5 clk = ~clk;

  assign x_vld = lv[XN-1:0];
  assign y_vld = lv[NL-1:XN];
  assign x_qos = lq[XN-1:0];
  assign y_qos = lq[NL-1:XN];
  assign rdy   = {y_rdy, x_rdy};

  for (genvar i = 0; i < XN; i++) begin : g_x
    assign x_type[i*TW +: TW] = lt[i];
    assign x_src[i*IW +: IW]  = ls[i];
    assign x_tgt[i*IW +: IW]  = lg[i];
    assign x_data[i*FW +: FW] = ld[i];
  end
  for (genvar i = 0; i < YN; i++) begin : g_y
    assign y_type[i*TW +: TW] = lt[XN+i];
    assign y_src[i*IW +: IW]  = ls[XN+i];
    assign y_tgt[i*IW +: IW]  = lg[XN+i];
    assign y_data[i*FW +: FW] = ld[XN+i];
  end

  pkt_con_rx_arb #(
    .X_NUM(XN), .Y_NUM(YN), .DEPTH(DEPTH), .TYPE_W(TW), .ID_W(IW), .FLIT_W(FW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .x_vld(x_vld), .x_qos(x_qos), .x_type(x_type), .x_src(x_src), .x_tgt(x_tgt),
    .x_data(x_data), .x_rdy(x_rdy),
    .y_vld(y_vld), .y_qos(y_qos), .y_type(y_type), .y_src(y_src), .y_tgt(y_tgt),
    .y_data(y_data), .y_rdy(y_rdy),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_qos(out_qos), .out_type(out_type),
    .out_src(out_src), .out_tgt(out_tgt), .out_data(out_data), .out_port(out_port),
    .fifo_cnt(fifo_cnt), .proto_err(proto_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_link(input int i, input logic q, input logic [FW-1:0] d);
    lv[i] = 1'b1;
    lq[i] = q;
    lt[i] = TW'(i);
    ls[i] = IW'(i);
    lg[i] = IW'(NL - 1 - i);
    ld[i] = d;
  endtask

  task automatic clear_links();
    lv = '0;
    lq = '0;
    for (int i = 0; i < NL; i++) begin
      lt[i] = '0; ls[i] = '0; lg[i] = '0; ld[i] = '0;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    next_cycle();
    rst_n   = 1'b0;
    out_rdy = 1'b0;
    clear_links();
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    out_rdy = 1'b0;
    clear_links();

    // Vectors applied back to back from reset, out_rdy=1; grants derived from rr pointers.
    tbl[0] = '{vld: 14'h0004, qos: 14'h0000, exp_rdy: 14'h0004};
    tbl[1] = '{vld: 14'h0021, qos: 14'h0000, exp_rdy: 14'h0020};
    tbl[2] = '{vld: 14'h0801, qos: 14'h0800, exp_rdy: 14'h0800};
    tbl[3] = '{vld: 14'h0001, qos: 14'h0000, exp_rdy: 14'h0001};
    tbl[4] = '{vld: 14'h3FFF, qos: 14'h0000, exp_rdy: 14'h0002};
    tbl[5] = '{vld: 14'h3FFF, qos: 14'h2008, exp_rdy: 14'h2000};
    tbl[6] = '{vld: 14'h3FFF, qos: 14'h2008, exp_rdy: 14'h0008};
    tbl[7] = '{vld: 14'h0000, qos: 14'h0000, exp_rdy: 14'h0000};
    tbl[8] = '{vld: 14'h00C0, qos: 14'h0000, exp_rdy: 14'h0040};
    tbl[9] = '{vld: 14'h00C0, qos: 14'h0000, exp_rdy: 14'h0080};

    // Reset state
    do_reset();
    sample();
    check("rst_cnt", 64'(fifo_cnt), 64'd0);
    check("rst_out_vld", 64'(out_vld), 64'd0);
    check("rst_proto_err", 64'(proto_err), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_rdy", 64'(rdy), 64'd0);

    // Single packet latency
    next_cycle();
    out_rdy = 1'b1;
    set_link(2, 1'b0, FW'(16'h00A5));
    sample();
    check("single_rdy", 64'(rdy), 64'h0004);
    check("single_cnt0", 64'(fifo_cnt), 64'd0);
    next_cycle();
    lv[2] = 1'b0;
    sample();
    check("single_out_vld", 64'(out_vld), 64'd1);
    check("single_out_data", 64'(out_data), 64'h00A5);
    check("single_out_port", 64'(out_port), 64'd2);
    check("single_cnt1", 64'(fifo_cnt), 64'd1);

    // QoS priority
    do_reset();
    out_rdy = 1'b1;
    set_link(0, 1'b0, FW'(16'h1111));
    set_link(11, 1'b1, FW'(16'h2222));
    sample();
    check("qos_first_rdy", 64'(rdy), 64'h0800);
    next_cycle();
    lv[11] = 1'b0;
    sample();
    check("qos_second_rdy", 64'(rdy), 64'h0001);
    check("qos_head_port", 64'(out_port), 64'd11);
    check("qos_head_qos", 64'(out_qos), 64'd1);
    next_cycle();
    lv[0] = 1'b0;
    sample();
    check("qos_next_port", 64'(out_port), 64'd0);
    check("qos_next_data", 64'(out_data), 64'h1111);

    // Vector table
    do_reset();
    out_rdy = 1'b1;
    for (int i = 0; i < NL; i++) set_link(i, 1'b0, FW'(16'hA500 + i));
    for (int v = 0; v < 10; v++) begin
      lv = tbl[v].vld;
      lq = tbl[v].qos;
      sample();
      check($sformatf("tbl%0d_rdy", v), 64'(rdy), 64'(tbl[v].exp_rdy));
      next_cycle();
    end

    // Round-robin fairness with all links requesting
    do_reset();
    out_rdy = 1'b1;
    for (int i = 0; i < NL; i++) set_link(i, 1'b0, FW'(16'hB000 + i));
    for (int k = 0; k < 15; k++) begin
      sample();
      check($sformatf("rr%0d_rdy", k), 64'(rdy), 64'(1) << (k % NL));
      next_cycle();
    end

    // Full FIFO inhibit and resume
    do_reset();
    out_rdy = 1'b0;
    for (int i = 0; i < 5; i++) set_link(i, 1'b0, FW'(16'hC000 + i));
    for (int k = 0; k < 4; k++) begin
      sample();
      check($sformatf("full_fill%0d_rdy", k), 64'(rdy), 64'(1) << k);
      next_cycle();
      lv[k] = 1'b0;
    end
    sample();
    check("full_rdy", 64'(rdy), 64'd0);
    check("full_cnt", 64'(fifo_cnt), 64'd4);
    check("full_head_port", 64'(out_port), 64'd0);
    next_cycle();
    sample();
    check("full_hold_rdy", 64'(rdy), 64'd0);
    next_cycle();
    out_rdy = 1'b1;
    sample();
    check("full_nobypass_rdy", 64'(rdy), 64'd0);
    check("full_nobypass_cnt", 64'(fifo_cnt), 64'd4);
    next_cycle();
    sample();
    check("full_resume_cnt", 64'(fifo_cnt), 64'd3);
    check("full_resume_rdy", 64'(rdy), 64'h0010);
    check("full_resume_port", 64'(out_port), 64'd1);
    next_cycle();
    lv[4] = 1'b0;
    sample();
    check("full_pushpop_cnt", 64'(fifo_cnt), 64'd3);
    check("full_pushpop_port", 64'(out_port), 64'd2);

    // Protocol error: drop valid while stalled
    do_reset();
    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) set_link(i, 1'b0, FW'(16'hD000 + i));
    for (int k = 0; k < 4; k++) begin
      sample();
      next_cycle();
      lv[k] = 1'b0;
    end
    set_link(5, 1'b0, FW'(16'hD005));
    sample();
    check("perr_stall_rdy", 64'(rdy), 64'd0);
    check("perr_before", 64'(proto_err), 64'd0);
    next_cycle();
    lv[5] = 1'b0;
    sample();
    check("perr_same_cycle", 64'(proto_err), 64'd0);
    next_cycle();
    sample();
    check("perr_set", 64'(proto_err), 64'd1);
    repeat (3) next_cycle();
    sample();
    check("perr_sticky", 64'(proto_err), 64'd1);

    // Asynchronous reset mid-stream
    do_reset();
    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) set_link(i, 1'b0, FW'(16'hE000 + i));
    for (int k = 0; k < 3; k++) begin
      sample();
      next_cycle();
      lv[k] = 1'b0;
    end
    sample();
    check("arst_pre_cnt", 64'(fifo_cnt), 64'd3);
    check("arst_pre_rdy", 64'(rdy), 64'h0008);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_cnt", 64'(fifo_cnt), 64'd0);
    check("arst_out_vld", 64'(out_vld), 64'd0);
    check("arst_rdy", 64'(rdy), 64'd0);
    check("arst_out_data", 64'(out_data), 64'd0);
    next_cycle();
    rst_n = 1'b1;
    clear_links();
    set_link(1, 1'b0, FW'(16'hE101));
    set_link(5, 1'b0, FW'(16'hE105));
    out_rdy = 1'b1;
    sample();
    check("arst_rearb_rdy", 64'(rdy), 64'h0002);
    check("arst_rearb_vld", 64'(out_vld), 64'd0);

    // Random traffic against the queue-based reference model
    do_reset();
    mq.delete();
    phi   = 0;
    plo   = 0;
    perr  = 1'b0;
    ppend = '0;
    for (int i = 0; i < NL; i++) pprev[i] = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      int   win;
      int   base;
      logic anyq;
      ent_t hexp;
      ent_t e;
      logic [NL-1:0] erdy;
      for (int i = 0; i < NL; i++) begin
        if (!lv[i] && ($urandom_range(99) < 35)) begin
          lv[i] = 1'b1;
          lq[i] = ($urandom_range(3) == 0);
          lt[i] = TW'($urandom);
          ls[i] = IW'($urandom);
          lg[i] = IW'($urandom);
          ld[i] = FW'($urandom);
        end
      end
      out_rdy = ($urandom_range(99) < 55);
      sample();
      hexp = (mq.size() != 0) ? mq[0] : '0;
      check("rnd_cnt", 64'(fifo_cnt), 64'(mq.size()));
      check("rnd_out_vld", 64'(out_vld), 64'(mq.size() != 0));
      check("rnd_head", 64'({out_qos, out_type, out_src, out_tgt, out_data, out_port}), 64'(hexp));
      check("rnd_proto_err", 64'(proto_err), 64'(perr));
      win  = -1;
      anyq = |(lv & lq);
      if (mq.size() < DEPTH) begin
        base = anyq ? phi : plo;
        for (int k = 0; k < NL; k++) begin
          int j;
          j = (base + k) % NL;
          if (win < 0 && lv[j] && (!anyq || lq[j])) win = j;
        end
      end
      erdy = (win >= 0) ? (NL'(1) << win) : '0;
      check("rnd_rdy", 64'(rdy), 64'(erdy));
      for (int i = 0; i < NL; i++) begin
        if (ppend[i] && (!lv[i] || ({lq[i], lt[i], ls[i], lg[i], ld[i]} != pprev[i]))) perr = 1'b1;
        ppend[i] = lv[i] && (win != i);
        pprev[i] = {lq[i], lt[i], ls[i], lg[i], ld[i]};
      end
      if (mq.size() != 0 && out_rdy) void'(mq.pop_front());
      if (win >= 0) begin
        e.q = lq[win]; e.t = lt[win]; e.s = ls[win]; e.g = lg[win]; e.d = ld[win]; e.p = 4'(win);
        mq.push_back(e);
        if (anyq) phi = (win + 1) % NL;
        else      plo = (win + 1) % NL;
      end
      next_cycle();
      if (win >= 0) lv[win] = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pkt_con_rx_arb.md
Name: pkt_con_rx_arb

Overview:
- Receiving (slv) end of the node/topology packet connection bundle.
- Accepts packets from 7 X-direction links (same x, different y) and 7 Y-direction links (same y, different x).
- Grants one transfer per cycle under QoS-aware round-robin arbitration and buffers accepted packets in a small FIFO.
- Presents packets on a single valid/ready local ejection port, so a node can drain all incoming connections through one port.

Parameters:
- X_NUM, 7, number of X-direction input links.
- Y_NUM, 7, number of Y-direction input links.
- DEPTH, 4, ejection FIFO entries; must be ≥2.
- TYPE_W, `TYPE_W, packet type width.
- ID_W, `ID_W, src/tgt id width.
- FLIT_W, `FLIT_W, payload width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- x_vld  in  X_NUM  per-link valid.
- x_qos  in  X_NUM  per-link high-priority flag.
- x_type  in  X_NUM*TYPE_W  link i at [i*TYPE_W +: TYPE_W].
- x_src  in  X_NUM*ID_W  source ids, packed as for x_type.
- x_tgt  in  X_NUM*ID_W  target ids, packed as for x_type.
- x_data  in  X_NUM*FLIT_W  payloads, packed as for x_type.
- x_rdy  out  X_NUM  per-link ready (grant).
- y_vld, y_qos, y_type, y_src, y_tgt, y_data, y_rdy: Y_NUM copies, same widths and packing as the x_* ports.
- out_vld  out  1  FIFO head valid.
- out_rdy  in  1  downstream ready.
- out_qos  out  1  head qos.
- out_type  out  TYPE_W  head type.
- out_src  out  ID_W  head source id.
- out_tgt  out  ID_W  head target id.
- out_data  out  FLIT_W  head payload.
- out_port  out  4  index of the link the head packet arrived on.
- fifo_cnt  out  $clog2(DEPTH+1)  occupancy.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset:
  - count, pointers and proto_err clear to 0.
  - out_* payload fields drive 0 while empty.
  - All x_rdy/y_rdy are 0 while rst_n is low.
- Link indexing: req[13:0] = {y_vld, x_vld}. Index 0..6 = x links, 7..13 = y links; out_port uses this index.
- Transfer on link i when vld[i] && rdy[i]. At most one rdy bit is high per cycle (one-hot or zero).
- Arbitration (combinational, same cycle):
  - If any requester has qos=1, arbitrate among qos requesters only; otherwise among all requesters.
  - Each class has its own round-robin pointer. Search begins at the pointer and wraps 13→0.
  - After a transfer, only the winning class pointer updates, to (winner+1) mod 14.
- Grant inhibit: no grant while fifo_cnt == DEPTH. A same-cycle pop does NOT free a slot for that cycle (no full bypass).
- FIFO:
  - Push stores {qos, type, src, tgt, data, port}.
  - Pop on out_vld && out_rdy; out_vld = (count != 0).
  - Outputs are driven from the registered head entry.
  - Latency: a packet accepted in cycle N is visible on out_* in cycle N+1 if the FIFO was empty.
  - Simultaneous push and pop leaves count unchanged.
  - Read/write pointers wrap modulo DEPTH.
- Sender protocol: once vld[i]=1, the sender holds vld and payload stable until rdy[i]=1. rdy may depend combinationally on vld; vld must not depend on rdy.
- proto_err:
  - Set if link i had vld=1, rdy=0 in cycle N and vld=0 in cycle N+1.
  - Also set if its payload changed between those cycles.
  - Sticky until reset.
  - Requires one registered previous-cycle vld/payload compare per link.
- out_* stability: out_vld and the head fields never change while out_vld=1 && out_rdy=0.
- Reset mid-operation: FIFO contents are discarded, count returns to 0, pending requests are re-arbitrated from pointer 0 after release.

Decomposition:
- Package pkt_con_pkg:
  - X_NUM, Y_NUM, TOTAL_NUM=14 constants.
  - port_idx_t (4 bits).
  - pkt_t struct {qos, type, src, tgt, data}.
  - fifo_ent_t struct {pkt_t, port_idx_t}.
- Sub-module pkt_con_rr_arb:
  - Parameter N; inputs req[N-1:0], ptr; outputs one-hot gnt and encoded index.
  - Instantiated twice (qos class, all class); the top selects between them.

Test Plan:
- Single packet: x_vld[2]=1, qos=0, data=0xA5, FIFO empty, out_rdy=1 → x_rdy[2]=1 same cycle; next cycle out_vld=1, out_data=0xA5, out_port=2, fifo_cnt=1.
- QoS priority: x_vld[0] qos=0 and y_vld[4] qos=1 together → y_rdy[4] granted first (out_port=11), then x_rdy[0].
- Round-robin fairness: all 14 links valid, qos=0, out_rdy=1 → grant order 0,1,…,13,0; each link served once per 14 grants.
- Full FIFO: out_rdy=0, 5 links valid, DEPTH=4 → exactly 4 grants, fifo_cnt=4, all rdy=0. Raise out_rdy → one pop per cycle, and grants resume the cycle after count<4.
- Protocol error: x_vld[5]=1 with FIFO full, then drop x_vld[5] before rdy → proto_err=1 next cycle and it stays 1.
- Async reset mid-stream: assert rst_n=0 with fifo_cnt=3 → fifo_cnt=0, out_vld=0, all rdy=0 immediately, without waiting for a clock edge.
